// File: rtl/reset_seq_pkg.sv
// Shared types for the staged reset sequencer.
// Optional watchdog is enabled with RESET_SEQ_WATCHDOG_EN.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POWER = 2'd0,
    CAUSE_SW    = 2'd1,
    CAUSE_WDT   = 2'd2
  } cause_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// Async-assert, sync-deassert reset synchronizer.
// Optional watchdog of the parent is enabled with RESET_SEQ_WATCHDOG_EN.
module reset_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release with software request/ack and cause reporting.
// Define RESET_SEQ_WATCHDOG_EN to add the watchdog resequence.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 8,
  parameter int WDT_CYCLES  = 2**24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_reset_req,
  output logic                  sw_reset_ack,
  input  logic                  wdt_kick,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  busy,
  output logic [1:0]            last_cause
);

  localparam int CNT_W = $clog2(max2(HOLD_CYCLES, STAGE_DELAY) + 1);
  localparam int IDX_W = $clog2(NUM_STAGES + 1);

  logic                  rst_sync;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  pending_q, pending_d;
  logic                  ack_q, ack_d;
  logic                  req_q, req_d;
  cause_t                cause_q, cause_d;
  logic                  sw_edge;

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES);
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             wdt_fire;
  assign wdt_fire = (wdt_q == WDT_W'(WDT_CYCLES - 1)) & ~wdt_kick;
`else
  logic unused_cfg;
  assign unused_cfg = wdt_kick ^ (WDT_CYCLES > 0);
`endif

  reset_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .rst_sync(rst_sync)
  );

  assign sw_edge = sw_reset_req & ~req_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_d     = rst_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    cause_d   = cause_q;
    req_d     = sw_reset_req;
`ifdef RESET_SEQ_WATCHDOG_EN
    wdt_d     = '0;
`endif
    unique case (state_q)
      S_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == IDX_W'(i)) rst_d[i] = 1'b0;
          end
          // The last stage release is also the S_RUN entry edge.
          if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
            state_d   = S_RUN;
            ack_d     = pending_q;
            pending_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        rst_d = '0;
`ifdef RESET_SEQ_WATCHDOG_EN
        wdt_d = wdt_kick ? '0 : wdt_q + 1'b1;
`endif
        if (sw_edge) begin
          state_d   = S_HOLD;
          cnt_d     = '0;
          rst_d     = '1;
          cause_d   = CAUSE_SW;
          pending_d = 1'b1;
`ifdef RESET_SEQ_WATCHDOG_EN
          wdt_d     = '0;
        end else if (wdt_fire) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          rst_d   = '1;
          cause_d = CAUSE_WDT;
          wdt_d   = '0;
`endif
        end
      end
      default: state_d = S_HOLD;
    endcase
    // Synchronized reset still asserted: pin everything at its reset value.
    if (rst_sync) begin
      state_d   = S_HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      rst_d     = '1;
      pending_d = 1'b0;
      ack_d     = 1'b0;
      cause_d   = CAUSE_POWER;
      req_d     = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
      wdt_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_q     <= '1;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      cause_q   <= CAUSE_POWER;
      req_q     <= 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
      wdt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_q     <= rst_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      cause_q   <= cause_d;
      req_q     <= req_d;
`ifdef RESET_SEQ_WATCHDOG_EN
      wdt_q     <= wdt_d;
`endif
    end
  end

  assign rst_out      = rst_q;
  assign busy         = (state_q != S_RUN);
  assign sw_reset_ack = ack_q;
  assign last_cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (elapsed-time reference model).
// Watchdog scenario is built when RESET_SEQ_WATCHDOG_EN is defined.
module tb_reset_sequencer;

  localparam int N      = 3;
  localparam int SYNC   = 2;
  localparam int HOLD   = 16;
  localparam int SD     = 8;
  localparam int WDT    = 64;
  localparam int RUN_AT = HOLD + N * SD;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sw_reset_req = 1'b0;
  logic         wdt_kick = 1'b0;
  logic         sw_reset_ack;
  logic         busy;
  logic [N-1:0] rst_out;
  logic [1:0]   last_cause;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES (N),
    .SYNC_STAGES(SYNC),
    .HOLD_CYCLES(HOLD),
    .STAGE_DELAY(SD),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_reset_req(sw_reset_req),
    .sw_reset_ack(sw_reset_ack),
    .wdt_kick    (wdt_kick),
    .rst_out     (rst_out),
    .busy        (busy),
    .last_cause  (last_cause)
  );

  // Model: m_since = clock edges since the current hold began
  // (negative while the synchronizer still holds reset).
  int         m_since;
  bit         m_pending;
  bit         m_prev;
  bit         m_ack;
  logic [1:0] m_cause;
  logic       m_run;
  logic       m_edge;
  logic [N-1:0] m_rst;
`ifdef RESET_SEQ_WATCHDOG_EN
  int         m_wdt;
`endif

  assign m_run  = (m_since >= RUN_AT);
  assign m_edge = sw_reset_req && !m_prev;

  always_comb begin
    for (int k = 0; k < N; k++) m_rst[k] = (m_since < HOLD + (k + 1) * SD);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_since   <= -SYNC;
      m_pending <= 1'b0;
      m_prev    <= 1'b0;
      m_ack     <= 1'b0;
      m_cause   <= 2'd0;
`ifdef RESET_SEQ_WATCHDOG_EN
      m_wdt     <= 0;
`endif
    end else begin
      m_ack  <= 1'b0;
      m_prev <= (m_since < 0) ? 1'b0 : sw_reset_req;
      if (!m_run) begin
        m_since <= m_since + 1;
`ifdef RESET_SEQ_WATCHDOG_EN
        m_wdt   <= 0;
`endif
        if (m_since + 1 == RUN_AT && m_pending) begin
          m_ack     <= 1'b1;
          m_pending <= 1'b0;
        end
      end else if (m_edge) begin
        m_since   <= 0;
        m_pending <= 1'b1;
        m_cause   <= 2'd1;
`ifdef RESET_SEQ_WATCHDOG_EN
        m_wdt     <= 0;
      end else if (wdt_kick) begin
        m_wdt <= 0;
      end else if (m_wdt == WDT - 1) begin
        m_since <= 0;
        m_cause <= 2'd2;
        m_wdt   <= 0;
      end else begin
        m_wdt <= m_wdt + 1;
`endif
      end
    end
  end

  logic [N+3:0] obs, expv;
  assign obs  = {rst_out, busy, sw_reset_ack, last_cause};
  assign expv = {m_rst, !m_run, m_ack, m_cause};

  task automatic test_reset();
    int fall[N];
    int busy_fall;
    for (int k = 0; k < N; k++) fall[k] = -1;
    busy_fall = -1;
    reset = 1'b1;
    sw_reset_req = 1'b0;
    wdt_kick = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (obs !== {{N{1'b1}}, 1'b1, 1'b0, 2'd0})
      $display("FAIL reset_state got %b want %b", obs, {{N{1'b1}}, 4'b1000});
    else n_pass++;
    reset = 1'b0;
    for (int c = 1; c <= RUN_AT + 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL reset_seq c=%0d got %b want %b", c, obs, expv);
      else n_pass++;
      for (int k = 0; k < N; k++) if (fall[k] < 0 && rst_out[k] === 1'b0) fall[k] = c;
      if (busy_fall < 0 && busy === 1'b0) busy_fall = c;
    end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (fall[k] != SYNC + HOLD + (k + 1) * SD)
        $display("FAIL stage%0d_latency got %0d want %0d", k, fall[k], SYNC + HOLD + (k + 1) * SD);
      else n_pass++;
    end
    n_checks++;
    if (busy_fall != SYNC + RUN_AT) $display("FAIL busy_latency got %0d want %0d", busy_fall, SYNC + RUN_AT);
    else n_pass++;
    n_checks++;
    if (last_cause !== 2'd0) $display("FAIL power_cause got %0d want 0", last_cause);
    else n_pass++;
  endtask

  task automatic test_sw_pulse();
    int acks = 0;
    sw_reset_req = 1'b1;
    for (int c = 1; c <= RUN_AT + 6; c++) begin
      @(negedge clk);
      sw_reset_req = 1'b0;
      if (c == 1) begin
        n_checks++;
        if (rst_out !== {N{1'b1}}) $display("FAIL sw_assert got %b want %b", rst_out, {N{1'b1}});
        else n_pass++;
      end
      n_checks++;
      if (obs !== expv) $display("FAIL sw_pulse c=%0d got %b want %b", c, obs, expv);
      else n_pass++;
      if (sw_reset_ack === 1'b1) acks++;
    end
    n_checks++;
    if (acks != 1 || last_cause !== 2'd1 || busy !== 1'b0)
      $display("FAIL sw_pulse_end got acks=%0d cause=%0d busy=%b want 1/1/0", acks, last_cause, busy);
    else n_pass++;
  endtask

  task automatic test_sw_held();
    int acks = 0;
    int busy_cycles = 0;
    sw_reset_req = 1'b1;
    for (int c = 1; c <= 3 * RUN_AT; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL sw_held c=%0d got %b want %b", c, obs, expv);
      else n_pass++;
      if (sw_reset_ack === 1'b1) acks++;
      if (busy === 1'b1) busy_cycles++;
    end
    n_checks++;
    if (acks != 1 || busy_cycles != RUN_AT)
      $display("FAIL sw_held_once got acks=%0d busy=%0d want 1/%0d", acks, busy_cycles, RUN_AT);
    else n_pass++;
    sw_reset_req = 1'b0;
    repeat (2) @(negedge clk);
    sw_reset_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL sw_reedge got busy=%b want 1", busy);
    else n_pass++;
    sw_reset_req = 1'b0;
    for (int c = 0; c < RUN_AT + 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL sw_reedge c=%0d got %b want %b", c, obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_edge_in_release();
    int acks = 0;
    int busy_cycles = 0;
    for (int c = 0; c < 3 * RUN_AT; c++) begin
      sw_reset_req = (c == 0 || c == HOLD + 4 || c == HOLD + SD + 3);
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL rel_edge c=%0d got %b want %b", c, obs, expv);
      else n_pass++;
      if (sw_reset_ack === 1'b1) acks++;
      if (busy === 1'b1) busy_cycles++;
    end
    sw_reset_req = 1'b0;
    n_checks++;
    if (acks != 1 || busy_cycles != RUN_AT)
      $display("FAIL rel_edge_ignored got acks=%0d busy=%0d want 1/%0d", acks, busy_cycles, RUN_AT);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    bit found = 1'b0;
    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
    for (int c = 0; c < 2 * RUN_AT && !found; c++) begin
      @(negedge clk);
      if (rst_out === 3'b110) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL mid_reach got rst_out=%b want 110", rst_out);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (rst_out !== 3'b111 || busy !== 1'b1)
      $display("FAIL mid_async got rst=%b busy=%b want 111/1", rst_out, busy);
    else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= SYNC + RUN_AT + 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL mid_seq c=%0d got %b want %b", c, obs, expv);
      else n_pass++;
      if (sw_reset_ack === 1'b1) acks++;
    end
    n_checks++;
    if (acks != 0 || last_cause !== 2'd0 || busy !== 1'b0)
      $display("FAIL mid_end got acks=%0d cause=%0d busy=%b want 0/0/0", acks, last_cause, busy);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) sw_reset_req = ~sw_reset_req;
      wdt_kick = ($urandom_range(0, 39) == 0);
      if (!reset && $urandom_range(0, 699) == 0) reset = 1'b1;
      else if (reset && $urandom_range(0, 2) == 0) reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL random c=%0d got %b want %b", c, obs, expv);
      else n_pass++;
    end
    reset = 1'b0;
    sw_reset_req = 1'b0;
    wdt_kick = 1'b0;
    repeat (SYNC + RUN_AT + 4) @(negedge clk);
  endtask

`ifdef RESET_SEQ_WATCHDOG_EN
  task automatic test_wdt();
    int cyc = -1;
    int fires = 0;
    sw_reset_req = 1'b0;
    wdt_kick = 1'b0;
    for (int c = 0; c < 2 * RUN_AT && busy !== 1'b0; c++) @(negedge clk);
    for (int c = 0; c <= WDT + 4 && cyc < 0; c++) begin
      if (busy === 1'b1) cyc = c;
      else @(negedge clk);
    end
    n_checks++;
    if (cyc != WDT || last_cause !== 2'd2)
      $display("FAIL wdt_fire got cyc=%0d cause=%0d want %0d/2", cyc, last_cause, WDT);
    else n_pass++;
    for (int c = 0; c < 2 * RUN_AT && busy !== 1'b0; c++) @(negedge clk);
    for (int c = 0; c < 8 * WDT; c++) begin
      wdt_kick = (c % 32 == 31);
      @(negedge clk);
      if (busy === 1'b1) fires++;
      n_checks++;
      if (obs !== expv) $display("FAIL wdt_kick c=%0d got %b want %b", c, obs, expv);
      else n_pass++;
    end
    wdt_kick = 1'b0;
    n_checks++;
    if (fires != 0) $display("FAIL wdt_kept got fires=%0d want 0", fires);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_sw_pulse();
    test_sw_held();
    test_edge_in_release();
    test_reset_mid();
    test_random();
`ifdef RESET_SEQ_WATCHDOG_EN
    test_wdt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
